// File: rtl/mx4_chk_pkg.sv
// Shared types and constants for the MX4 exhaustive sweep checker.
// The stim field offsets define how the 12-bit vector maps onto d0..d3, s0 and s1.
package mx4_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VEC = 4096;
  localparam int STIM_W  = 12;
  localparam int Y_W     = 20;

  localparam int D0_LSB = 0;
  localparam int D1_LSB = 2;
  localparam int D2_LSB = 4;
  localparam int D3_LSB = 6;
  localparam int S0_LSB = 8;
  localparam int S1_LSB = 10;

  // 4:1 mux: x1 selects the upper pair, x0 selects within the pair
  function automatic logic mx(input logic a0, input logic a1, input logic a2,
                              input logic a3, input logic x0, input logic x1);
    return x1 ? (x0 ? a3 : a2) : (x0 ? a1 : a0);
  endfunction

endpackage

// File: rtl/mx4_ref_model.sv
// Combinational golden model of the 20-output MX4 test top: stim -> expected y.
module mx4_ref_model
  import mx4_chk_pkg::*;
(
  input  logic [STIM_W-1:0] stim,
  output logic [Y_W-1:0]    y_exp
);

  logic [1:0] d0, d1, d2, d3, s0, s1;

  assign d0 = stim[D0_LSB +: 2];
  assign d1 = stim[D1_LSB +: 2];
  assign d2 = stim[D2_LSB +: 2];
  assign d3 = stim[D3_LSB +: 2];
  assign s0 = stim[S0_LSB +: 2];
  assign s1 = stim[S1_LSB +: 2];

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign y_exp[gi]      = mx(d0[gi], d1[gi], d2[gi], d3[gi], s0[gi], s1[gi]);
      assign y_exp[10 + gi] = s0[gi];
      // Upper outputs mix constant and live selects; gi plays the role of the constant here
      assign y_exp[16 + gi] = mx(d0[0], d1[0], d2[0], d3[0], gi == 1, s1[0]);
      assign y_exp[18 + gi] = mx(d0[1], d1[1], d2[1], d3[1], s0[1], gi == 1);
      for (gj = 0; gj < 2; gj++) begin : g_sel0
        assign y_exp[12 + 2*gi + gj] = (gi == 1);
        for (gk = 0; gk < 2; gk++) begin : g_sel1
          assign y_exp[2 + 4*gi + 2*gj + gk] =
            mx(d0[gi], d1[gi], d2[gi], d3[gi], gj == 1, gk == 1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mx4_sweep_checker.sv
// Exhaustive 4096-vector stimulus/response checker around the MX4 test top.
// Optional MX4_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module mx4_sweep_checker
  import mx4_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [STIM_W-1:0] stim,
  input  logic [Y_W-1:0]    y_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [STIM_W-1:0] first_fail_vec
);

  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [STIM_W-1:0] LAST_VEC    = STIM_W'(NUM_VEC - 1);

  state_t            state_reg, state_next;
  logic [STIM_W-1:0] stim_reg, stim_next;
  logic [STIM_W-1:0] vec_reg, vec_next;
  logic [STIM_W-1:0] ffv_reg, ffv_next;
  logic [3:0]        settle_reg, settle_next;
  logic [ERR_W-1:0]  err_reg, err_next;
  logic [Y_W-1:0]    y_exp;
  logic              mismatch;
  logic              stop_now;

  mx4_ref_model u_ref (
    .stim  (stim_reg),
    .y_exp (y_exp)
  );

  // y_dut is judged in CHECK itself, so the DUT sees a stable vector for SETTLE_CYCLES+1 cycles
  assign mismatch = (y_dut != y_exp);

`ifdef MX4_CHK_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      stim_reg   <= '0;
      vec_reg    <= '0;
      ffv_reg    <= '0;
      settle_reg <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      stim_reg   <= stim_next;
      vec_reg    <= vec_next;
      ffv_reg    <= ffv_next;
      settle_reg <= settle_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stim_next   = stim_reg;
    vec_next    = vec_reg;
    ffv_next    = ffv_reg;
    settle_next = settle_reg;
    err_next    = err_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = DRIVE;
          vec_next   = '0;
          err_next   = '0;
          ffv_next   = '0;
        end
      end
      DRIVE: begin
        stim_next   = vec_reg;
        settle_next = '0;
        state_next  = SETTLE;
      end
      SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = CHECK;
        end else begin
          settle_next = settle_reg + 4'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_reg != '1) err_next = err_reg + ERR_W'(1);
          if (err_reg == '0) ffv_next = stim_reg;
        end
        if (stop_now || vec_reg == LAST_VEC) begin
          state_next = DONE;
        end else begin
          vec_next   = vec_reg + STIM_W'(1);
          state_next = DRIVE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy           = (state_reg == DRIVE) || (state_reg == SETTLE) || (state_reg == CHECK);
  assign done           = (state_reg == DONE);
  assign pass           = done && (err_reg == '0);
  assign err_count      = err_reg;
  assign first_fail_vec = ffv_reg;
  assign stim           = stim_reg;

endmodule
